// File: rtl/fp_special_classify.sv
// ----------------------------------------------------------------------------
// fp_special_classify
//   Classifies an IEEE-754 style floating-point operand as NaN, infinity,
//   zero or subnormal, and passes its sign bit through. All outputs are
//   registered, so the latency is one cycle and one operand can be accepted
//   every cycle.
//
//   Optional feature macro: FP_SPECIAL_DAZ_EN
//     When defined, the block treats denormals as zero: subnormal operands
//     report zero=1 and subnormal=0. The sign bit still passes through.
//
// Parameters
//   DATA_W     total word width (sign + exponent + mantissa)
//   EXP_W      exponent field width; mantissa is DATA_W-EXP_W-1 bits
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   rst_i      synchronous, active-high reset; clears every output
//   data_i     operand {sign, exponent, mantissa}
//   nan        exponent all ones, mantissa non-zero (quiet or signalling)
//   infinite   exponent all ones, mantissa zero
//   zero       exponent zero, mantissa zero (also subnormals under DAZ)
//   subnormal  exponent zero, mantissa non-zero (never set under DAZ)
//   sign       sign bit of the operand, for every class
// ----------------------------------------------------------------------------
module fp_special_classify #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              nan,
    output logic              infinite,
    output logic              zero,
    output logic              subnormal,
    output logic              sign
);

    localparam int MAN_W = DATA_W - EXP_W - 1;

    logic [EXP_W-1:0] exp_field;
    logic [MAN_W-1:0] man_field;
    logic             exp_ones;
    logic             exp_zero;
    logic             man_nz;

    logic nan_d, inf_d, zero_d, sub_d, sign_d;
    logic nan_q, inf_q, zero_q, sub_q, sign_q;

    assign exp_field = data_i[DATA_W-2 -: EXP_W];
    assign man_field = data_i[MAN_W-1:0];
    assign exp_ones  = &exp_field;
    assign exp_zero  = ~|exp_field;
    assign man_nz    = |man_field;

    // The four class flags come from disjoint exponent/mantissa conditions,
    // so at most one of them can be set for any operand.
    always_comb begin
        nan_d  = exp_ones &  man_nz;
        inf_d  = exp_ones & ~man_nz;
        sign_d = data_i[DATA_W-1];
`ifdef FP_SPECIAL_DAZ_EN
        // Denormals flush to zero: any zero exponent reports as zero.
        zero_d = exp_zero;
        sub_d  = 1'b0;
`else
        zero_d = exp_zero & ~man_nz;
        sub_d  = exp_zero &  man_nz;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
            sub_q  <= 1'b0;
            sign_q <= 1'b0;
        end else begin
            nan_q  <= nan_d;
            inf_q  <= inf_d;
            zero_q <= zero_d;
            sub_q  <= sub_d;
            sign_q <= sign_d;
        end
    end

    assign nan       = nan_q;
    assign infinite  = inf_q;
    assign zero      = zero_q;
    assign subnormal = sub_q;
    assign sign      = sign_q;

endmodule

// File: tb/tb_fp_special_classify.sv
// ----------------------------------------------------------------------------
// tb_fp_special_classify
//   Bench for fp_special_classify at 32/8 and 16/5 widths. A behavioural
//   model derives each class from the exponent/mantissa values; a per-cycle
//   compare process checks both instances against it, and a directed
//   sequence pins the model with hand-computed literal results.
//   Flag vector order everywhere: {nan, infinite, zero, subnormal, sign}.
// ----------------------------------------------------------------------------
module tb_fp_special_classify;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] d32;
    logic [15:0] d16;

    logic nan32, inf32, zero32, sub32, sign32;
    logic nan16, inf16, zero16, sub16, sign16;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fp_special_classify #(.DATA_W(32), .EXP_W(8)) dut32 (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(d32),
        .nan(nan32), .infinite(inf32), .zero(zero32),
        .subnormal(sub32), .sign(sign32)
    );

    fp_special_classify #(.DATA_W(16), .EXP_W(5)) dut16 (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(d16),
        .nan(nan16), .infinite(inf16), .zero(zero16),
        .subnormal(sub16), .sign(sign16)
    );

    wire [4:0] got32 = {nan32, inf32, zero32, sub32, sign32};
    wire [4:0] got16 = {nan16, inf16, zero16, sub16, sign16};

`ifdef FP_SPECIAL_DAZ_EN
    localparam bit DAZ = 1'b1;
`else
    localparam bit DAZ = 1'b0;
`endif

    // Behavioural classification from field values.
    function automatic logic [4:0] model(input logic [63:0] d, input int dw, input int ew);
        int          mw;
        logic [63:0] e, m, emax;
        logic        s;
        mw   = dw - ew - 1;
        emax = (64'd1 << ew) - 64'd1;
        e    = (d >> mw) & emax;
        m    = d & ((64'd1 << mw) - 64'd1);
        s    = d[dw-1];
        if (e == emax)   return (m != 0) ? {4'b1000, s} : {4'b0100, s};
        else if (e == 0) begin
            if (m == 0 || DAZ) return {4'b0010, s};
            else               return {4'b0001, s};
        end
        return {4'b0000, s};
    endfunction

    // Expected outputs after each edge, captured from inputs stable at the edge.
    logic [4:0] exp32, exp16;
    logic       mvalid = 1'b0;

    always @(posedge clk_i) begin
        exp32  <= rst_i ? 5'b0 : model({32'b0, d32}, 32, 8);
        exp16  <= rst_i ? 5'b0 : model({48'b0, d16}, 16, 5);
        mvalid <= 1'b1;
    end

    always @(negedge clk_i) begin
        if (mvalid) begin
            checks = checks + 2;
            if (got32 !== exp32) begin
                failures = failures + 1;
                $display("FAIL cyc32 t=%0t got=%b want=%b", $time, got32, exp32);
            end
            if (got16 !== exp16) begin
                failures = failures + 1;
                $display("FAIL cyc16 t=%0t got=%b want=%b", $time, got16, exp16);
            end
        end
    end

    // Directed steps: drive, wait one edge, compare against a literal.
    task automatic lit32(input string nm, input logic [31:0] d, input logic [4:0] want);
        d32 = d;
        @(posedge clk_i); #2;
        checks = checks + 1;
        if (got32 !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%b want=%b", nm, got32, want);
        end
    endtask

    task automatic lit16(input string nm, input logic [15:0] d, input logic [4:0] want);
        d16 = d;
        @(posedge clk_i); #2;
        checks = checks + 1;
        if (got16 !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%b want=%b", nm, got16, want);
        end
    endtask

    // Random operand biased toward the special exponent values.
    function automatic logic [63:0] gen(input int dw, input int ew);
        logic [63:0] r, emask;
        int          mw;
        mw    = dw - ew - 1;
        emask = ((64'd1 << ew) - 64'd1) << mw;
        r     = {$urandom, $urandom} & ((64'd1 << dw) - 64'd1);
        case ($urandom_range(0, 5))
            0: r = r & ~emask;                                   // exp zero
            1: r = r | emask;                                    // exp all ones
            2: r = (r & ~emask) & ~((64'd1 << mw) - 64'd1);      // +/- zero
            3: r = (r | emask) & ~((64'd1 << mw) - 64'd1);       // +/- inf
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        rst_i = 1'b1;
        d16   = 16'h7FFF;
        lit32("rst_all_zero", 32'h7FFFFFFF, 5'b00000);
        rst_i = 1'b0;
        lit32("first_zero",  32'h00000000, 5'b00100);
        lit32("max_subnorm", 32'h007FFFFF, DAZ ? 5'b00100 : 5'b00010);
        lit32("neg_inf",     32'hFF800000, 5'b01001);
        lit32("pos_inf",     32'h7F800000, 5'b01000);
        lit32("neg_nan",     32'hFFFFFFFF, 5'b10001);
        lit32("qnan",        32'h7FC00000, 5'b10000);
        lit32("snan",        32'h7F800001, 5'b10000);
        lit32("one",         32'h3F800000, 5'b00000);
        lit32("neg_zero",    32'h80000000, 5'b00101);
        lit16("h_inf",       16'h7C00,     5'b01000);
        lit16("h_nan",       16'h7E00,     5'b10000);
        lit16("h_subnorm",   16'h0001,     DAZ ? 5'b00100 : 5'b00010);
        lit16("h_neg_norm",  16'hBC00,     5'b00001);

        // Mid-stream reset: a NaN in flight must be discarded.
        d32 = 32'hFFC00000;
        rst_i = 1'b1;
        lit32("mid_rst", 32'hFFC00000, 5'b00000);
        rst_i = 1'b0;
        lit32("post_rst", 32'h00000001, DAZ ? 5'b00100 : 5'b00010);

        // Random traffic with occasional resets; checked each cycle.
        for (int i = 0; i < 3000; i++) begin
            d32   = gen(32, 8);
            d16   = gen(16, 5);
            rst_i = ($urandom_range(0, 99) < 3);
            @(posedge clk_i); #2;
        end
        rst_i = 1'b0;
        @(posedge clk_i); #2;
        @(negedge clk_i); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_special_classify.md
FP_SPECIAL_CLASSIFY -- requirements
Module: fp_special

Interface
REQ-001 Parameter DATA_W, default 32, total floating-point word width in bits.
REQ-002 Parameter EXP_W, default 8, exponent field width; mantissa width MAN_W = DATA_W-EXP_W-1.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 data_i  input  DATA_W  operand; bit DATA_W-1 = sign, next EXP_W bits = exponent, low MAN_W bits = mantissa.
REQ-006 nan  output  1  operand is NaN.
REQ-007 infinite  output  1  operand is +/- infinity.
REQ-008 zero  output  1  operand is +/- zero.
REQ-009 subnormal  output  1  operand is subnormal (denormal).
REQ-010 sign  output  1  sign bit of the operand.

Function
REQ-011 Exponent all-ones and mantissa non-zero SHALL set nan=1; quiet and signalling NaNs are not distinguished.
REQ-012 Exponent all-ones and mantissa zero SHALL set infinite=1, regardless of sign.
REQ-013 Exponent zero and mantissa zero SHALL set zero=1, regardless of sign.
REQ-014 Exponent zero and mantissa non-zero SHALL set subnormal=1 (without FP_SPECIAL_DAZ_EN).
REQ-015 Any other exponent (normal number) SHALL drive nan, infinite, zero and subnormal to 0.
REQ-016 At most one of nan, infinite, zero, subnormal SHALL be 1 in any cycle.
REQ-017 sign SHALL equal data_i[DATA_W-1] for every class, including NaN.
REQ-018 All outputs SHALL be registered: outputs reflect data_i sampled at rising edge N, valid after that edge; latency exactly 1 cycle, throughput one operand per cycle.
REQ-019 Classification SHALL be correct for any DATA_W >= EXP_W+2 and EXP_W >= 2; no hard-coded widths.

Reset
REQ-020 While rst_i is 1 at a rising edge, all outputs SHALL be 0 at that edge, overriding data_i.
REQ-021 The first edge with rst_i=0 SHALL register the classification of the data_i value present at that edge.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight classification; no history is retained.

Configuration
REQ-023 Macro FP_SPECIAL_DAZ_EN, when defined, SHALL make subnormal operands report zero=1 and subnormal=0 (denormals-are-zero); sign still passes through.
REQ-024 Without FP_SPECIAL_DAZ_EN, subnormal operands SHALL report subnormal=1 and zero=0.

Verification (DATA_W=32, EXP_W=8; values are output one cycle after drive)
REQ-025 rst_i=1, data_i=0x7FFFFFFF -> all outputs 0; release reset, data_i=0x00000000 -> zero=1, sign=0, others 0.
REQ-026 data_i=0x007FFFFF -> subnormal=1, zero=0 without macro; zero=1, subnormal=0 with FP_SPECIAL_DAZ_EN.
REQ-027 data_i=0xFF800000 -> infinite=1, sign=1; data_i=0x7F800000 -> infinite=1, sign=0.
REQ-028 data_i=0xFFFFFFFF -> nan=1, sign=1; data_i=0x7FC00000 -> nan=1; data_i=0x7F800001 -> nan=1.
REQ-029 data_i=0x3F800000 (1.0) and 0x80000000 -> all class flags 0 then zero=1 with sign=1, on consecutive cycles, checking 1-cycle latency back-to-back.
REQ-030 Sweep with DATA_W=16, EXP_W=5: 0x7C00 -> infinite=1, 0x7E00 -> nan=1, 0x0001 -> subnormal=1.
